// File: rtl/mb_fetch_ctrl.sv
// rtl/mb_fetch_ctrl.sv - macroblock fetch controller (optional MB_FETCH_CTRL_PERF_EN stall counter)
module mb_fetch_ctrl #(
    parameter int HMACRO_CNT = 79,
    parameter int MB_ROWS    = 45,
    parameter int Y_WORDS    = 64,
    parameter int MB_WORDS   = 96
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        buf_r_valid,
    output logic        buf_r_ready,
    output logic [6:0]  buf_r_addr,
    input  logic        buf_data_valid,
    input  logic [31:0] buf_data,
    input  logic        enc_start,
    output logic        enc_valid,
    input  logic        enc_ready,
    output logic [31:0] enc_data,
    output logic        enc_is_y,
    output logic        enc_last,
    output logic [6:0]  mb_x,
    output logic [5:0]  mb_y,
    output logic        frame_end,
    output logic        busy
`ifdef MB_FETCH_CTRL_PERF_EN
    ,
    output logic [15:0] perf_stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BUF,
        S_WAIT_START,
        S_FETCH,
        S_DRAIN,
        S_RELEASE
    } state_t;

    localparam logic [6:0] LAST_ADDR = 7'(MB_WORDS - 1);
    localparam logic [6:0] Y_LIMIT   = 7'(Y_WORDS);
    localparam logic [6:0] LAST_X    = 7'(HMACRO_CNT);
    localparam logic [5:0] LAST_Y    = 6'(MB_ROWS - 1);

    state_t      state;
    logic [6:0]  issue_cnt;
    logic [6:0]  ret_cnt;
    logic        inflight;
    logic [31:0] fifo_data [4];
    logic [3:0]  fifo_y;
    logic [3:0]  fifo_last;
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  fifo_cnt;

    logic        credit_ok;
    logic        issue;
    logic        push;
    logic        pop;
    logic        mb_done;
    logic        frame_done;

    // A read may only be issued when every outstanding word still has a FIFO slot;
    // a return with nothing in flight is a buffer fault and is dropped.
    always_comb begin
        credit_ok   = ({1'b0, fifo_cnt} + {3'b000, inflight}) < 4'd4;
        issue       = (state == S_FETCH) && buf_r_valid && credit_ok;
        push        = buf_data_valid && inflight;
        enc_valid   = (fifo_cnt != 3'd0);
        enc_data    = enc_valid ? fifo_data[rd_ptr] : 32'h0;
        enc_is_y    = enc_valid && fifo_y[rd_ptr];
        enc_last    = enc_valid && fifo_last[rd_ptr];
        pop         = enc_valid && enc_ready;
        buf_r_ready = issue;
        buf_r_addr  = issue ? issue_cnt : 7'd0;
        busy        = (state == S_FETCH) || (state == S_DRAIN);
        mb_done     = (state == S_DRAIN) && pop && enc_last;
        frame_done  = mb_done && (mb_x == LAST_X) && (mb_y == LAST_Y);
    end

    // Control FSM: stripe handshake, read sequencing and macroblock position.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            issue_cnt <= 7'd0;
            mb_x      <= 7'd0;
            mb_y      <= 6'd0;
            frame_end <= 1'b0;
        end else begin
            frame_end <= frame_done;
            case (state)
                S_IDLE:       state <= S_WAIT_BUF;
                S_WAIT_BUF:   if (buf_r_valid) state <= S_WAIT_START;
                S_WAIT_START: begin
                    if (enc_start) begin
                        state     <= S_FETCH;
                        issue_cnt <= 7'd0;
                    end
                end
                S_FETCH: begin
                    if (issue) begin
                        issue_cnt <= issue_cnt + 7'd1;
                        if (issue_cnt == LAST_ADDR) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (mb_done) begin
                        if (mb_x == LAST_X) begin
                            mb_x  <= 7'd0;
                            state <= S_RELEASE;
                            mb_y  <= (mb_y == LAST_Y) ? 6'd0 : mb_y + 6'd1;
                        end else begin
                            mb_x  <= mb_x + 7'd1;
                            state <= S_WAIT_START;
                        end
                    end
                end
                S_RELEASE:    if (!buf_r_valid) state <= S_WAIT_BUF;
                default:      state <= S_IDLE;
            endcase
        end
    end

    // Return tracking and FIFO occupancy; return index drives the Y/last tags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            ret_cnt  <= 7'd0;
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            fifo_cnt <= 3'd0;
        end else begin
            if (issue)               inflight <= 1'b1;
            else if (buf_data_valid) inflight <= 1'b0;
            if ((state == S_WAIT_START) && enc_start) ret_cnt <= 7'd0;
            else if (push)                            ret_cnt <= ret_cnt + 7'd1;
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            fifo_cnt <= fifo_cnt + {2'b00, push} - {2'b00, pop};
        end
    end

    // FIFO storage; contents are don't-care while the entry is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= buf_data;
            fifo_y[wr_ptr]    <= (ret_cnt < Y_LIMIT);
            fifo_last[wr_ptr] <= (ret_cnt == LAST_ADDR);
        end
    end

`ifdef MB_FETCH_CTRL_PERF_EN
    // Count FETCH cycles lost to the credit limit; restarts at each frame end.
    always_ff @(posedge clk) begin
        if (!rst_n || frame_done) begin
            perf_stall_cnt <= 16'h0;
        end else if ((state == S_FETCH) && buf_r_valid && !credit_ok &&
                     (perf_stall_cnt != 16'hFFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 16'h1;
        end
    end
`endif

endmodule

// File: doc/mb_fetch_ctrl.md
MB_FETCH_CTRL -- requirements
Module: mb_fetch_ctrl

Interface
REQ-001 SHALL have parameter HMACRO_CNT, default 79: index of the last macroblock in a 16-line stripe.
REQ-002 SHALL have parameter MB_ROWS, default 45: number of stripes per frame.
REQ-003 SHALL have parameter Y_WORDS, default 64, and MB_WORDS, default 96: Y words and total 32-bit words per macroblock.
REQ-004 SHALL have one clock, clk, input, 1 bit; all logic is rising-edge.
REQ-005 SHALL have rst_n, input, 1 bit; the reset is synchronous and active-low.
REQ-006 SHALL have buf_r_valid, input, 1 bit: the stripe buffer holds a complete stripe.
REQ-007 SHALL have buf_r_ready, output, 1 bit: read-issue strobe to the buffer.
REQ-008 SHALL have buf_r_addr, output, 7 bits: word index within the macroblock, 0..95.
REQ-009 SHALL have buf_data_valid, input, 1 bit, and buf_data, input, 32 bits: the buffer's read return.
REQ-010 SHALL have enc_start, input, 1 bit: the encoder requests the next macroblock.
REQ-011 SHALL have the output stream enc_valid (output, 1), enc_ready (input, 1), enc_data (output, 32), enc_is_y (output, 1) and enc_last (output, 1).
REQ-012 SHALL have the status outputs mb_x (output, 7), mb_y (output, 6), frame_end (output, 1, pulse) and busy (output, 1).

Function
REQ-013 SHALL implement the states IDLE, WAIT_BUF, WAIT_START, FETCH, DRAIN and RELEASE.
REQ-014 SHALL move IDLE->WAIT_BUF one cycle after reset release.
REQ-015 SHALL move WAIT_BUF->WAIT_START when buf_r_valid=1.
REQ-016 SHALL, in WAIT_START, move to FETCH on enc_start=1 and clear the issue counter; enc_start SHALL be ignored in every other state.
REQ-017 SHALL, in FETCH, assert buf_r_ready for one cycle per read, with buf_r_addr equal to the issue counter, only when buf_r_valid=1 and (fifo_count + inflight) < 4.
REQ-018 SHALL issue at most one read per cycle, with addresses strictly sequential 0..MB_WORDS-1 and none skipped or repeated.
REQ-019 SHALL hold the issue counter, with buf_r_ready=0, while buf_r_valid=0 mid-FETCH, and SHALL resume at the same address when buf_r_valid returns to 1.
REQ-020 SHALL move FETCH->DRAIN in the cycle after the read for address MB_WORDS-1 is issued.
REQ-021 SHALL treat buffer latency as fixed at 1 cycle: inflight is set on issue and cleared on return.
REQ-022 SHALL push each buf_data word into a 4-entry output FIFO in the cycle buf_data_valid=1.
REQ-023 SHALL tag each FIFO entry with is_y = (word index < Y_WORDS) and last = (word index == MB_WORDS-1).
REQ-024 SHALL drive enc_valid = FIFO not empty and enc_data/enc_is_y/enc_last from the FIFO head.
REQ-025 SHALL pop the FIFO on enc_valid && enc_ready, and SHALL hold the head stable while enc_ready=0.
REQ-026 SHALL leave DRAIN in the cycle after the enc_last word is accepted, with the FIFO empty and inflight=0.
REQ-027 SHALL, on leaving DRAIN with mb_x < HMACRO_CNT, increment mb_x and go to WAIT_START.
REQ-028 SHALL, on leaving DRAIN with mb_x == HMACRO_CNT, set mb_x=0 and go to RELEASE.
REQ-029 SHALL, on that stripe end, increment mb_y; if mb_y == MB_ROWS-1, SHALL set mb_y=0 and pulse frame_end for exactly 1 cycle.
REQ-030 SHALL stay in RELEASE until buf_r_valid=0, then go to WAIT_BUF, so that a stale buf_r_valid never starts a new stripe.
REQ-031 SHALL treat buf_data_valid with inflight=0 as a buffer fault: the data is discarded and the FIFO is unchanged.
REQ-032 SHALL drive busy=1 in FETCH and DRAIN, and 0 otherwise.

Reset
REQ-033 SHALL, when rst_n=0 at a clock edge, force state IDLE, empty the FIFO, and clear the issue counter, inflight and the perf counter.
REQ-034 SHALL reset buf_r_ready, buf_r_addr, enc_valid, enc_data, enc_is_y, enc_last, mb_x, mb_y, frame_end and busy to 0.
REQ-035 SHALL, on reset mid-FETCH or mid-DRAIN, abandon the macroblock, emit no further enc_valid, and start again from mb_x=0, mb_y=0.

Configuration
REQ-036 SHALL, with macro MB_FETCH_CTRL_PERF_EN defined, add output perf_stall_cnt (16 bits).
REQ-037 SHALL increment perf_stall_cnt, saturating at 0xFFFF, on each FETCH cycle where buf_r_valid=1 but no read was issued because the credit limit was reached.
REQ-038 SHALL clear perf_stall_cnt in the cycle frame_end pulses.
REQ-039 SHALL, with MB_FETCH_CTRL_PERF_EN undefined, omit the port and the counter and leave all other behaviour identical.

Verification
REQ-040 SHALL cover: buf_r_valid=1, enc_start pulse, enc_ready=1 -> 96 reads at addresses 0..95 on consecutive cycles; 64 words with enc_is_y=1 then 32 with 0; enc_last only on word 96; mb_x 0->1.
REQ-041 SHALL cover: enc_ready=0 after an enc_start pulse -> exactly 4 reads issued, then buf_r_ready=0; FIFO head held; on enc_ready=1, reads resume at address 4.
REQ-042 SHALL cover: buf_r_valid dropped for 5 cycles after address 30 -> no reads during the gap; the next read is at address 31; total reads = 96.
REQ-043 SHALL cover: 80 macroblocks completed with buf_r_valid held 1 -> state stays RELEASE; buf_r_valid 1->0->1 -> WAIT_BUF then WAIT_START; mb_x=0, mb_y=1.
REQ-044 SHALL cover: MB_ROWS=2, two stripes completed -> frame_end high 1 cycle; mb_y=0; perf_stall_cnt cleared (PERF_EN build).
REQ-045 SHALL cover: rst_n=0 at address 50 -> next cycle all outputs 0; state IDLE; after release a new enc_start fetch begins at address 0.
